// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_SKID_STATS_EN to add the saturating stall/transfer counters.
module pipe_stage_skid #(
   parameter int               WIDTH      = 144,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = {4'd1, {(WIDTH-4){1'b0}}},
   parameter int               CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
`ifdef PIPE_SKID_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] xfer_cnt_o
`endif
);

   // Encoding is {skid_vld, main_vld}; 2'b10 is unreachable and recovers to EMPTY.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             main_vld;
   logic             skid_vld;
   logic             acc;
   logic             dlv;
   logic             load_main;
   logic             main_from_skid;
   logic             load_skid;

   assign acc = in_valid_i & in_ready_o;
   assign dlv = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_i) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  state_nxt = ONE;
                  load_main = 1'b1;
               end
            end
            ONE: begin
               if (acc && dlv) begin
                  load_main = 1'b1;
               end else if (acc) begin
                  state_nxt = FULL;
                  load_skid = 1'b1;
               end else if (dlv) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (dlv) begin
                  state_nxt      = ONE;
                  main_from_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      main_vld    = (state == ONE) || (state == FULL);
      skid_vld    = (state == FULL);
      in_ready_o  = ~skid_vld;
      out_valid_o = main_vld;
      out_data_o  = main_vld ? main_q : BUBBLE_VAL;
   end

   // Payload registers carry no reset; the state alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (load_main) begin
         main_q <= in_data_i;
      end else if (main_from_skid) begin
         main_q <= skid_q;
      end
      if (load_skid) begin
         skid_q <= in_data_i;
      end
   end

`ifdef PIPE_SKID_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] xfer_q;

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
         xfer_q  <= '0;
      end else begin
         if (out_valid_o && !out_ready_i) begin
            stall_q <= sat_inc(stall_q);
         end
         if (dlv) begin
            xfer_q <= sat_inc(xfer_q);
         end
      end
   end

   assign stall_cnt_o = stall_q;
   assign xfer_cnt_o  = xfer_q;
`endif

endmodule
